usb_mode_reset_ctrl: RTL and testbench



---
 rtl/usb_mode_reset_ctrl.sv | 148 ++++++++++++++
 tb/tb_usb_mode_reset_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/usb_mode_reset_ctrl.sv
// usb_mode_reset_ctrl
//   USB core reset sequencer. A change of usb_working_mode, or a sw_reset_req
//   pulse, starts a sequence: usb_reset_n is held low for RST_CYCLES cycles,
//   then a SETTLE_CYCLES window passes before reset_done pulses. A new trigger
//   at any point restarts the sequence and relatches the mode.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     usb_working_mode  requested mode (synchronous to clk)
//     sw_reset_req      single-cycle request for a reset in the current mode
//     usb_reset_n       registered active-low reset to the USB core
//     mode_latched      mode for the core/endpoint mux, updated only on trigger
//     reset_busy        high from trigger until completion
//     reset_done        single-cycle completion pulse
//     reset_count       (USB_RESET_STATS_EN only) saturating trigger count
//
//   Build option: define USB_RESET_STATS_EN to add reset_count.
//
//   state  | meaning
//   IDLE   | no sequence running, core out of reset
//   ASSERT | usb_reset_n held low, counting RST_CYCLES
//   SETTLE | core released, counting SETTLE_CYCLES before reset_done
module usb_mode_reset_ctrl #(
  parameter int MODE_W        = 2,
  parameter int RST_CYCLES    = 64,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] usb_working_mode,
  input  logic              sw_reset_req,
  output logic              usb_reset_n,
  output logic [MODE_W-1:0] mode_latched,
  output logic              reset_busy,
  output logic              reset_done
`ifdef USB_RESET_STATS_EN
  ,
  output logic [7:0]        reset_count
`endif
);

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  // SETTLE is never entered when SETTLE_CYCLES is 0, so its value is irrelevant then.
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ASSERT, SETTLE} state_t;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [MODE_W-1:0] mode_d;
  logic [MODE_W-1:0] mode_latched_nxt;
  logic              usb_reset_n_nxt;
  logic              reset_busy_nxt;
  logic              reset_done_nxt;
  logic              trigger;

  assign trigger = (usb_working_mode != mode_d) || sw_reset_req;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mode_d       <= '0;
      mode_latched <= '0;
      usb_reset_n  <= 1'b1;
      reset_busy   <= 1'b0;
      reset_done   <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      mode_d       <= usb_working_mode;
      mode_latched <= mode_latched_nxt;
      usb_reset_n  <= usb_reset_n_nxt;
      reset_busy   <= reset_busy_nxt;
      reset_done   <= reset_done_nxt;
    end
  end

  // Next state; a trigger always wins, including on a completion edge.
  always_comb begin
    state_nxt = state_q;
    if (trigger) begin
      state_nxt = ASSERT;
    end else begin
      case (state_q)
        ASSERT: begin
          if (cnt_q == RST_LAST) begin
            if (SETTLE_CYCLES == 0) state_nxt = IDLE;
            else                    state_nxt = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) state_nxt = IDLE;
        end
        default: state_nxt = state_q;
      endcase
    end
  end

  // Next values of the registered outputs and counter
  always_comb begin
    cnt_nxt          = '0;
    usb_reset_n_nxt  = 1'b1;
    reset_busy_nxt   = 1'b0;
    reset_done_nxt   = 1'b0;
    mode_latched_nxt = mode_latched;
    if (trigger) begin
      usb_reset_n_nxt  = 1'b0;
      reset_busy_nxt   = 1'b1;
      mode_latched_nxt = usb_working_mode;
    end else begin
      case (state_q)
        ASSERT: begin
          if (cnt_q == RST_LAST) begin
            // With no settle window, completion coincides with the release edge.
            if (SETTLE_CYCLES == 0) reset_done_nxt = 1'b1;
            else                    reset_busy_nxt = 1'b1;
          end else begin
            usb_reset_n_nxt = 1'b0;
            reset_busy_nxt  = 1'b1;
            cnt_nxt         = cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            reset_done_nxt = 1'b1;
          end else begin
            reset_busy_nxt = 1'b1;
            cnt_nxt        = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef USB_RESET_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           reset_count <= 8'd0;
    else if (trigger && reset_count != 8'hFF) reset_count <= reset_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_usb_mode_reset_ctrl.sv
// Testbench for usb_mode_reset_ctrl. Two instances share the stimulus: one with
// default timing and one with RST_CYCLES=1, SETTLE_CYCLES=0. A timeline model
// (trigger edge number plus fixed durations) predicts outputs; predictions are
// queued at stimulus time and a separate monitor compares after each edge.
module tb_usb_mode_reset_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       sw = 1'b0;

  logic       rn_a, busy_a, done_a;
  logic [1:0] ml_a;
  logic       rn_b, busy_b, done_b;
  logic [1:0] ml_b;
`ifdef USB_RESET_STATS_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  usb_mode_reset_ctrl #(.MODE_W(2), .RST_CYCLES(64), .SETTLE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .usb_working_mode(mode), .sw_reset_req(sw),
    .usb_reset_n(rn_a), .mode_latched(ml_a), .reset_busy(busy_a), .reset_done(done_a)
`ifdef USB_RESET_STATS_EN
    , .reset_count(cnt_a)
`endif
  );

  usb_mode_reset_ctrl #(.MODE_W(2), .RST_CYCLES(1), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .usb_working_mode(mode), .sw_reset_req(sw),
    .usb_reset_n(rn_b), .mode_latched(ml_b), .reset_busy(busy_b), .reset_done(done_b)
`ifdef USB_RESET_STATS_EN
    , .reset_count(cnt_b)
`endif
  );

  typedef struct {
    logic       rn;
    logic       busy;
    logic       done;
    logic [1:0] ml;
    int         cnt;
  } exp_t;

  typedef struct {
    int         e;
    int         t_trig;
    bit         active;
    logic [1:0] prev;
    logic [1:0] ml;
    int         cnt;
  } mst_t;

  exp_t q_a[$];
  exp_t q_b[$];
  mst_t st_a, st_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Timeline model: after edge e, the core is in reset while e < t_trig+R,
  // busy while e < t_trig+R+S, and done exactly at e == t_trig+R+S.
  function automatic exp_t step(inout mst_t st, input int r_cyc, input int s_cyc,
                                input logic [1:0] m, input logic s, input logic r);
    exp_t x;
    bit   trig;
    st.e++;
    if (!r) begin
      st.prev = 2'd0; st.active = 0; st.ml = 2'd0; st.cnt = 0;
      x.rn = 1'b1; x.busy = 1'b0; x.done = 1'b0; x.ml = 2'd0; x.cnt = 0;
      return x;
    end
    trig = (m != st.prev) || s;
    st.prev = m;
    if (trig) begin
      st.t_trig = st.e;
      st.active = 1;
      st.ml     = m;
      if (st.cnt < 255) st.cnt++;
    end
    x.rn   = !(st.active && st.e < st.t_trig + r_cyc);
    x.busy = st.active && st.e < st.t_trig + r_cyc + s_cyc;
    x.done = st.active && !trig && st.e == st.t_trig + r_cyc + s_cyc;
    if (st.active && st.e >= st.t_trig + r_cyc + s_cyc) st.active = 0;
    x.ml   = st.ml;
    x.cnt  = st.cnt;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next edge.
  task automatic cyc(input logic [1:0] m, input logic s, input logic r);
    logic was_run;
    @(negedge clk);
    was_run = rst_n;
    mode  = m;
    sw    = s;
    rst_n = r;
    q_a.push_back(step(st_a, 64, 16, m, s, r));
    q_b.push_back(step(st_b, 1, 0, m, s, r));
    if (was_run && !r) begin
      #1;
      check("async_rst_usb_reset_n", int'(rn_a), 1);
      check("async_rst_busy", int'(busy_a), 0);
      check("async_rst_mode_latched", int'(ml_a), 0);
      check("async_rst_usb_reset_n_b", int'(rn_b), 1);
    end
  endtask

  task automatic run(input int n, input logic [1:0] m);
    repeat (n) cyc(m, 1'b0, 1'b1);
  endtask

  // Monitor: one prediction per edge, compared 2 time units after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      while (q_a.size() > 0) begin
        x = q_a.pop_front();
        check("a_usb_reset_n", int'(rn_a), int'(x.rn));
        check("a_reset_busy", int'(busy_a), int'(x.busy));
        check("a_reset_done", int'(done_a), int'(x.done));
        check("a_mode_latched", int'(ml_a), int'(x.ml));
`ifdef USB_RESET_STATS_EN
        check("a_reset_count", int'(cnt_a), x.cnt);
`endif
      end
      while (q_b.size() > 0) begin
        x = q_b.pop_front();
        check("b_usb_reset_n", int'(rn_b), int'(x.rn));
        check("b_reset_busy", int'(busy_b), int'(x.busy));
        check("b_reset_done", int'(done_b), int'(x.done));
        check("b_mode_latched", int'(ml_b), int'(x.ml));
`ifdef USB_RESET_STATS_EN
        check("b_reset_count", int'(cnt_b), x.cnt);
`endif
      end
    end
  end

  initial begin
    logic [1:0] m;
    st_a = '{e: 0, t_trig: 0, active: 0, prev: 2'd0, ml: 2'd0, cnt: 0};
    st_b = st_a;

    repeat (5) cyc(2'd0, 1'b0, 1'b0);
    run(200, 2'd0);                          // idle after reset
    run(100, 2'd2);                          // 0->2 full sequence
    run(30, 2'd1);                           // 2->1 then 1->3 restart
    run(120, 2'd3);
    run(69, 2'd2);                           // sw request 5 cycles into SETTLE
    cyc(2'd2, 1'b1, 1'b1);
    run(100, 2'd2);
    cyc(2'd1, 1'b1, 1'b1);                   // sw coincident with mode change
    run(100, 2'd1);
    run(20, 2'd2);                           // rst_n 20 cycles into ASSERT
    repeat (3) cyc(2'd2, 1'b0, 1'b0);
    run(100, 2'd2);
    run(80, 2'd3);                           // trigger exactly at completion edge
    run(10, 2'd0);
    run(100, 2'd0);

    m = 2'd0;
    for (int i = 0; i < 2000; i++) begin
      logic s, r;
      if ($urandom_range(0, 39) == 0) m = 2'($urandom_range(0, 3));
      s = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 499) != 0);
      cyc(m, s, r);
    end

    m = 2'd0;
    for (int i = 0; i < 300; i++) begin      // saturate the trigger count
      m = (m == 2'd0) ? 2'd1 : 2'd0;
      run(10, m);
    end
    run(100, m);

    @(posedge clk);
    #5;
    check("queues_drained", q_a.size() + q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
